// File: rtl/moore_pulse_tx.sv
// moore_pulse_tx: shifts a parallel word out LSB-first on enable ticks,
// with a per-bit strobe and a running mod-3 count of transmitted ones.
// All outputs are registered; busy/done are derived from the next state
// so they line up with the state the FSM occupies after each edge.
module moore_pulse_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             a,
  output logic             a_stb,
  output logic             busy,
  output logic             done,
  output logic [1:0]       ones_mod3
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             a_q,     a_d;
  logic             stb_q,   stb_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [1:0]       ones_q,  ones_d;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    stb_d   = 1'b0;
    ones_d  = ones_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d = data;
          cnt_d   = '0;
          ones_d  = 2'd0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (enable) begin
          a_d     = shreg_q[0];
          stb_d   = 1'b1;
          shreg_d = shreg_q >> 1;
          if (shreg_q[0]) begin
            ones_d = (ones_q == 2'd2) ? 2'd0 : ones_q + 2'd1;
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ones_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ones_q  <= ones_d;
    end
  end

  assign a         = a_q;
  assign a_stb     = stb_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ones_mod3 = ones_q;

endmodule
